// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - loader state encodings and memory depth derivation, shared with the bench
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_CSUM  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERROR = 3'd4
    } loader_state_t;

    function automatic int loader_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/imem_loader_csum.sv
// rtl/imem_loader_csum.sv - running program-word sum with a "sum plus candidate is zero" compare
module imem_loader_csum #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              i_clear,
    input  logic              i_add,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_zero
);

    logic [DATA_W-1:0] r_sum;
    logic [DATA_W-1:0] w_total;

    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_sum <= '0;
        end else if (i_add) begin
            r_sum <= r_sum + i_data;
        end
    end

    assign w_total = r_sum + i_data;
    assign o_zero  = (w_total == '0);

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams a program into instruction memory and holds the CPU in reset until done
// Optional trailing checksum word enabled by defining LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 32,
    parameter int RESET_HOLD = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W:0]   word_count
);

    localparam int DEPTH  = loader_depth(ADDR_W);
    localparam int HOLD_W = (RESET_HOLD < 1) ? 1 : $clog2(RESET_HOLD + 1);

    loader_state_t     r_state;
    logic              r_ready;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_count;
    logic [HOLD_W-1:0] r_hold;
    logic              r_cpu_reset;
    logic              r_done;
    logic              r_error;

    logic              w_xfer;
    logic              w_last_slot;

    assign w_xfer      = s_valid && r_ready;
    assign w_last_slot = (r_addr == ADDR_W'(DEPTH - 1));

`ifdef LOADER_CHECKSUM_EN
    logic w_csum_ok;

    imem_loader_csum #(
        .DATA_W (DATA_W)
    ) u_csum (
        .clk     (clk),
        .i_clear (reset),
        .i_add   (w_xfer && (r_state == ST_LOAD)),
        .i_data  (s_data),
        .o_zero  (w_csum_ok)
    );
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_LOAD;
            r_ready     <= 1'b0;
            r_we        <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_addr      <= '0;
            r_count     <= '0;
            r_hold      <= '0;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                ST_LOAD: begin
                    // s_ready is registered, so it first rises one cycle after reset
                    r_ready <= 1'b1;
                    if (w_xfer) begin
                        r_we    <= 1'b1;
                        r_waddr <= r_addr;
                        r_wdata <= s_data;
                        r_addr  <= r_addr + 1'b1;
                        if (r_count != (ADDR_W+1)'(DEPTH)) begin
                            r_count <= r_count + 1'b1;
                        end
                        if (s_last) begin
`ifdef LOADER_CHECKSUM_EN
                            r_state <= ST_CSUM;
`else
                            r_state <= ST_HOLD;
                            r_ready <= 1'b0;
                            r_hold  <= '0;
`endif
                        end else if (w_last_slot) begin
                            r_state <= ST_ERROR;
                            r_ready <= 1'b0;
                            r_error <= 1'b1;
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (w_xfer) begin
                        r_ready <= 1'b0;
                        if (w_csum_ok) begin
                            r_state <= ST_HOLD;
                            // no write pulse precedes this HOLD cycle, so it already counts
                            r_hold  <= HOLD_W'(1);
                        end else begin
                            r_state <= ST_ERROR;
                            r_error <= 1'b1;
                        end
                    end
                end
`endif
                ST_HOLD: begin
                    if (r_hold >= HOLD_W'(RESET_HOLD)) begin
                        r_state     <= ST_RUN;
                        r_cpu_reset <= 1'b0;
                        r_done      <= 1'b1;
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                ST_RUN: begin
                    r_ready <= 1'b0;
                end
                ST_ERROR: begin
                    r_ready <= 1'b0;
                end
                default: begin
                    r_state <= ST_ERROR;
                    r_ready <= 1'b0;
                    r_error <= 1'b1;
                end
            endcase
        end
    end

    assign s_ready    = r_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_waddr;
    assign imem_wdata = r_wdata;
    assign cpu_reset  = r_cpu_reset;
    assign load_done  = r_done;
    assign load_error = r_error;
    assign word_count = r_count;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int ADDR_W     = 6;
    localparam int DATA_W     = 32;
    localparam int RESET_HOLD = 2;
    localparam int DEPTH      = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              s_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic              cpu_reset;
    logic              load_done;
    logic              load_error;
    logic [ADDR_W:0]   word_count;

    imem_loader #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .RESET_HOLD (RESET_HOLD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .load_done  (load_done),
        .load_error (load_error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int exp_addr;
    int last_we_cyc;
    int fall_cyc;
    logic              prev_cr = 1'b1;
    logic [DATA_W-1:0] run_sum;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] img[DEPTH];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [ADDR_W+DATA_W-1:0] e;
        if (imem_we) begin
            last_we_cyc = cyc;
            check("we_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("we_addr", 64'(imem_addr), 64'(e[ADDR_W+DATA_W-1:DATA_W]));
                check("we_data", 64'(imem_wdata), 64'(e[DATA_W-1:0]));
            end
        end
        if (prev_cr && !cpu_reset) fall_cyc = cyc;
        prev_cr = cpu_reset;
    end

    task automatic do_reset();
        reset   = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b0;
        exp_addr = 0;
        run_sum  = '0;
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input logic last, input logic is_prog);
        logic got;
        int n;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        got     = 1'b0;
        n       = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            got = s_ready;
            @(posedge clk);
            #1;
            n++;
        end
        check("accept", 64'(got), 64'd1);
        if (got && is_prog) begin
            exp_q.push_back({exp_addr[ADDR_W-1:0], d});
            exp_addr++;
            run_sum = run_sum + d;
        end
    endtask

    task automatic idle_cycle();
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic load_image(input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            send(img[i], (i == n - 1), 1'b1);
            if (gap) idle_cycle();
        end
`ifdef LOADER_CHECKSUM_EN
        send(~run_sum + 1'b1, 1'b1, 1'b0);
`endif
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!load_done && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        check("load_done", 64'(load_done), 64'd1);
    endtask

    task automatic check_loaded(input string tag, input int n);
        check({tag, "_count"}, 64'(word_count), 64'(n));
        check({tag, "_cpu_reset"}, 64'(cpu_reset), 64'd0);
        check({tag, "_q_empty"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_state"}, 64'(dut.r_state), 64'(ST_RUN));
`ifndef LOADER_CHECKSUM_EN
        check({tag, "_release"}, 64'(fall_cyc - last_we_cyc), 64'(RESET_HOLD + 1));
`endif
    endtask

    initial begin
        int rc;
        int wc;
        for (int i = 0; i < DEPTH; i++) img[i] = $urandom;

        // reset state and first cycle after reset
        reset   = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'(s_ready), 64'd0);
        check("rst_we", 64'(imem_we), 64'd0);
        check("rst_addr", 64'(imem_addr), 64'd0);
        check("rst_wdata", 64'(imem_wdata), 64'd0);
        check("rst_cpu_reset", 64'(cpu_reset), 64'd1);
        check("rst_done", 64'(load_done), 64'd0);
        check("rst_error", 64'(load_error), 64'd0);
        check("rst_count", 64'(word_count), 64'd0);
        check("rst_state", 64'(dut.r_state), 64'(ST_LOAD));
        @(posedge clk);
        #1;
        reset    = 1'b0;
        exp_addr = 0;
        run_sum  = '0;
        @(negedge clk);
        check("first_cycle_ready", 64'(s_ready), 64'd0);
        @(posedge clk);
        #1;

        // 13-word image, valid held high
        load_image(13, 1'b0);
        wait_done();
        check_loaded("t1", 13);

        // same image with valid gaps
        do_reset();
        load_image(13, 1'b1);
        wait_done();
        check_loaded("t2", 13);

        // stream ignored once running
        rc = 0;
        wc = 0;
        s_valid = 1'b1;
        s_data  = 32'hDEADBEEF;
        repeat (10) begin
            @(negedge clk);
            if (s_ready) rc++;
            if (imem_we) wc++;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        check("run_ready_cnt", 64'(rc), 64'd0);
        check("run_we_cnt", 64'(wc), 64'd0);
        check("run_done_kept", 64'(load_done), 64'd1);

        // overflow: DEPTH words with no s_last
        do_reset();
        for (int i = 0; i < DEPTH; i++) send(img[i], 1'b0, 1'b1);
        s_valid = 1'b0;
        @(negedge clk);
        check("ovf_error", 64'(load_error), 64'd1);
        check("ovf_ready", 64'(s_ready), 64'd0);
        check("ovf_state", 64'(dut.r_state), 64'(ST_ERROR));
        check("ovf_count", 64'(word_count), 64'(DEPTH));
        rc = 0;
        repeat (100) begin
            @(negedge clk);
            if (!cpu_reset) rc++;
        end
        check("ovf_cpu_reset_low_cycles", 64'(rc), 64'd0);
        check("ovf_q_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;

        // reset mid-load, then a 3-word image
        do_reset();
        for (int i = 0; i < 6; i++) send(img[i + 20], 1'b0, 1'b1);
        do_reset();
        check("abort_q_empty", 64'(exp_q.size()), 64'd0);
        load_image(3, 1'b0);
        wait_done();
        check_loaded("t4", 3);

`ifdef LOADER_CHECKSUM_EN
        do_reset();
        send(32'h1, 1'b0, 1'b1);
        send(32'h2, 1'b0, 1'b1);
        send(32'h3, 1'b1, 1'b1);
        send(32'hFFFFFFFA, 1'b0, 1'b0);
        s_valid = 1'b0;
        wait_done();
        check("csum_ok_count", 64'(word_count), 64'd3);
        check("csum_ok_q_empty", 64'(exp_q.size()), 64'd0);
        check("csum_ok_error", 64'(load_error), 64'd0);

        do_reset();
        send(32'h1, 1'b0, 1'b1);
        send(32'h2, 1'b0, 1'b1);
        send(32'h3, 1'b1, 1'b1);
        send(32'hFFFFFFFB, 1'b1, 1'b0);
        s_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("csum_bad_error", 64'(load_error), 64'd1);
        check("csum_bad_done", 64'(load_done), 64'd0);
        check("csum_bad_cpu_reset", 64'(cpu_reset), 64'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
